scan_chain_responder: RTL
=========================

// Module: scan_chain_responder
// PURPOSE
// Target-side end of the scan snapshot interface: the shift chain that the scan controller IP drives.
// On scan_enable rise it freezes the user design (halt_req) and captures its parallel state into a CHAIN_LEN-bit chain.
// It then shifts old state out on scan_output while shifting new state in from scan_input.
// It hands the new state back for restore through a valid/ready handshake. Synthesizable replacement for the bench chain model.
// PARAMETERS
// CHAIN_LEN  128                     chain length in bits; must be >= 2
// CNT_W      $clog2(CHAIN_LEN+1)     width of shift_count
// PORTS
// aclk           in   1          clock; all state updates on rising edge
// aresetn        in   1          reset, asynchronous, active-high
// scan_enable    in   1          scan session active (from scan controller)
// scan_ck_enable in   1          shift strobe; one chain shift per cycle while high
// scan_input     in   1          serial data into chain bit 0
// scan_output    out  1          serial data out = chain[CHAIN_LEN-1] (registered)
// state_in       in   CHAIN_LEN  parallel live state of user design, sampled at capture
// halt_req       out  1          freeze request to user design
// state_out      out  CHAIN_LEN  new state for restore; stable while restore_valid
// restore_valid  out  1          state_out valid, hold until restore_ready
// restore_ready  in   1          user design accepted state_out
// shift_count    out  CNT_W      shifts performed in current session, saturating at CHAIN_LEN
// err_short      out  1          sticky: session ended with shift_count < CHAIN_LEN
// err_overrun    out  1          sticky: more than CHAIN_LEN shifts in session
// BEHAVIOUR
// - Reset (aresetn=1, async): FSM=IDLE, chain=0, se_q=0, all outputs 0.
// - se_q is a register of scan_enable.
// - rise = scan_enable & ~se_q.
// - fall = ~scan_enable & se_q.
// - IDLE: on rise, in the same edge: chain<=state_in, shift_count<=0, err_short<=0, err_overrun<=0, halt_req<=1, go SHIFT.
//   - scan_ck_enable in the capture cycle is ignored.
//   - scan_enable held high without a rise never captures.
// - SHIFT, scan_enable=1 and scan_ck_enable=1:
//   - chain <= {chain[CHAIN_LEN-2:0], scan_input}.
//   - shift_count increments if < CHAIN_LEN.
//   - If shift_count already == CHAIN_LEN: set err_overrun; chain still shifts, count stays.
// - SHIFT, scan_enable=1 and scan_ck_enable=0: hold.
// - SHIFT on fall:
//   - shift_count==CHAIN_LEN and !err_overrun: state_out<=chain, restore_valid<=1, go RESTORE.
//   - shift_count<CHAIN_LEN: err_short<=1, halt_req<=0, go IDLE, no restore.
//   - err_overrun set: halt_req<=0, go IDLE, no restore.
// - RESTORE:
//   - Hold state_out and restore_valid until restore_ready=1 is sampled.
//   - On that edge: restore_valid<=0, halt_req<=0, go IDLE.
//   - Handshake completes in 1 cycle if restore_ready is already high.
//   - scan_enable and scan_ck_enable are ignored.
//   - A rise during RESTORE is lost; the controller must toggle scan_enable again.
// - Bit order:
//   - First bit out is state_in[CHAIN_LEN-1]; first bit in ends at state_out[CHAIN_LEN-1].
//   - Loopback of scan_output to scan_input over CHAIN_LEN shifts reproduces state_in exactly.
// - Shift latency: scan_output changes 1 cycle after a sampled scan_ck_enable.
// - Reset mid-session: immediate return to reset values.
//   - halt_req and restore_valid drop asynchronously; any partial chain is discarded.
// - Error flags stay set until the next capture; errors never block a later session.
// TESTING
// T1 reset: aresetn=1 during activity -> scan_output=0, halt_req=0, restore_valid=0, state_out=0, shift_count=0.
// T2 loopback: state_in=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, rise, 128 strobes with scan_input=scan_output, fall
//    -> restore_valid=1, state_out==state_in; restore_ready after 3 cycles -> restore_valid=0, halt_req=0 next edge.
// T3 swap: state_in=all 1s, shift in 128 bits 1010.. (first bit 1) -> scan_output 128 ones in order, state_out=128'hAAAA..AA.
// T4 gapped strobes: T2 with scan_ck_enable high 1 cycle in 3, strobe also high in capture cycle -> identical result to T2.
// T5 short/overrun: 100 strobes then fall -> err_short=1, no restore_valid, halt_req=0.
//    130 strobes -> err_overrun=1, shift_count=128, no restore_valid.
//    Next clean session clears both flags.
// T6 reset mid-shift: aresetn pulse after 50 strobes -> IDLE, all outputs 0.
//    New rise then 128 strobes -> normal restore.

Source files
------------

// File: rtl/scan_chain_responder.sv
// Target-side scan chain: captures user state on session start, shifts it out
// while shifting replacement state in, then offers the new state for restore
// over a valid/ready handshake.
module scan_chain_responder #(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 scan_enable,
  input  logic                 scan_ck_enable,
  input  logic                 scan_input,
  output logic                 scan_output,
  input  logic [CHAIN_LEN-1:0] state_in,
  output logic                 halt_req,
  output logic [CHAIN_LEN-1:0] state_out,
  output logic                 restore_valid,
  input  logic                 restore_ready,
  output logic [CNT_W-1:0]     shift_count,
  output logic                 err_short,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESTORE
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

  state_t               state_q, state_d;
  logic                 se_q;
  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] state_out_d;
  logic [CNT_W-1:0]     count_d;
  logic                 halt_d, valid_d, err_short_d, err_overrun_d;
  logic                 rise, fall, strobe;

  assign rise        = scan_enable & ~se_q;
  assign fall        = ~scan_enable & se_q;
  assign strobe      = scan_enable & scan_ck_enable;
  assign scan_output = chain_q[CHAIN_LEN-1];

  // FSM state and scan_enable edge-detect register
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q <= IDLE;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      se_q    <= scan_enable;
    end
  end

  // Chain, counters, flags and handshake registers
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      chain_q       <= '0;
      state_out     <= '0;
      shift_count   <= '0;
      halt_req      <= 1'b0;
      restore_valid <= 1'b0;
      err_short     <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      chain_q       <= chain_d;
      state_out     <= state_out_d;
      shift_count   <= count_d;
      halt_req      <= halt_d;
      restore_valid <= valid_d;
      err_short     <= err_short_d;
      err_overrun   <= err_overrun_d;
    end
  end

  // Next-state and next-register logic for the capture/shift/restore session
  always_comb begin
    state_d       = state_q;
    chain_d       = chain_q;
    state_out_d   = state_out;
    count_d       = shift_count;
    halt_d        = halt_req;
    valid_d       = restore_valid;
    err_short_d   = err_short;
    err_overrun_d = err_overrun;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          chain_d       = state_in;
          count_d       = '0;
          err_short_d   = 1'b0;
          err_overrun_d = 1'b0;
          halt_d        = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        if (strobe) begin
          chain_d = {chain_q[CHAIN_LEN-2:0], scan_input};
          if (shift_count == FULL) begin
            err_overrun_d = 1'b1;
          end else begin
            count_d = shift_count + CNT_W'(1);
          end
        end else if (fall) begin
          if (shift_count == FULL && !err_overrun) begin
            state_out_d = chain_q;
            valid_d     = 1'b1;
            state_d     = RESTORE;
          end else begin
            if (shift_count != FULL) begin
              err_short_d = 1'b1;
            end
            halt_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      RESTORE: begin
        if (restore_ready) begin
          valid_d = 1'b0;
          halt_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
